// File: rtl/mp_ctrl_pkg.sv
// Shared constants for the multicycle control unit: FSM state encodings
// and the 2-bit opcode field (instr[7:6]) values.
package mp_ctrl_pkg;

  // FSM state encodings; these values are visible on state_o.
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_ADDR   = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_LWB    = 3'd6;
  localparam logic [2:0] S_JUMP   = 3'd7;

  // Opcode field instr[7:6].
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

endpackage

// File: rtl/mp_ack_timer.sv
// Counts consecutive un-acknowledged memory request cycles and flags
// 'expired' combinationally in the ACK_TIMEOUT-th such cycle, so the
// controller can abort on that same clock edge.
module mp_ack_timer
  import mp_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Clear has priority; otherwise count each waiting request cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  assign expired = en && (cnt_q == TW'(ACK_TIMEOUT - 1));

  // Wait-cycle counter register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mp_multicycle_ctrl.sv
// Multicycle control unit for the 8-bit microprocessor. Sequences
// FETCH/DECODE/EXEC/WB, ADDR/MEM/LWB and JUMP over one shared memory port.
// Optional build macro MP_CTRL_STEP_EN adds a 'step' input that gates
// each instruction fetch on a latched step pulse.
//
// Memory handshake: mem_req is held high for the whole access; an
// access completes in any cycle where mem_req=1 and mem_ack=1 (same-cycle
// ack is a zero-wait access). mem_ack while mem_req=0 is ignored.
// Outputs are Moore decodes of the state plus mem_ack, and are forced
// to 0 while Reset is high.
module mp_multicycle_ctrl
  import mp_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [7:0]       instr_i,
  input  logic             mem_ack,
`ifdef MP_CTRL_STEP_EN
  input  logic             step,
`endif
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             alu_src,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state_o
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             retire;
  logic             abort;
  logic             fetch_go;
  logic             req_int;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_expired;
  logic [1:0]       op;
  logic             unused_imm;

  assign op         = instr_i[7:6];
  assign unused_imm = ^instr_i[5:0];

`ifdef MP_CTRL_STEP_EN
  logic step_pend_q, step_pend_d;

  // Step latch: set by any pulse, cleared by a retire (a new pulse wins).
  always_comb begin
    step_pend_d = step | (step_pend_q & ~retire);
  end

  // Step latch register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      step_pend_q <= 1'b0;
    end else begin
      step_pend_q <= step_pend_d;
    end
  end

  assign fetch_go = step_pend_q;
`else
  assign fetch_go = 1'b1;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    req_int    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    alu_src    = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    abort      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          req_int = 1'b1;
          if (mem_ack) begin
            ir_load = 1'b1;
            pc_en   = 1'b1;
            state_d = S_DECODE;
          end else if (tmr_expired) begin
            abort   = 1'b1;
          end
        end
      end
      S_DECODE: begin
        case (op)
          OP_ADD:       state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        req_int = 1'b1;
        mem_we  = (op == OP_SW);
        alu_src = 1'b1;
        if (mem_ack) begin
          if (op == OP_LW) begin
            state_d = S_LWB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (tmr_expired) begin
          abort   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_LWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_en   = 1'b1;
        pc_sel  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // Nothing leaves the block while Reset is held.
    if (Reset) begin
      req_int    = 1'b0;
      mem_we     = 1'b0;
      ir_load    = 1'b0;
      pc_en      = 1'b0;
      pc_sel     = 1'b0;
      alu_src    = 1'b0;
      reg_we     = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  // Retire counter and sticky bus error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | abort;
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Timer restarts whenever a request phase begins or is aborted.
  assign tmr_en  = req_int & ~mem_ack;
  assign tmr_clr = ~req_int | abort | (state_d != state_q);

  mp_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .Reset   (Reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // State, counter and error registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_int;
  assign bus_err   = err_q;
  assign instr_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mp_multicycle_ctrl.sv
// Testbench for mp_multicycle_ctrl. Each instruction's expected per-cycle
// output vector is derived from the instruction table and pushed together
// with the stimulus; the cycle loop drives the stimulus and pops/compares.
module tb_mp_multicycle_ctrl;
  import mp_ctrl_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int W  = 3 + 8 + 1 + CW;

  localparam logic [7:0] ST_REQ    = 8'h80;
  localparam logic [7:0] ST_WE     = 8'h40;
  localparam logic [7:0] ST_IRL    = 8'h20;
  localparam logic [7:0] ST_PCEN   = 8'h10;
  localparam logic [7:0] ST_PCSEL  = 8'h08;
  localparam logic [7:0] ST_ALUSRC = 8'h04;
  localparam logic [7:0] ST_REGWE  = 8'h02;
  localparam logic [7:0] ST_M2R    = 8'h01;

  logic          clk = 1'b0;
  logic          Reset;
  logic [7:0]    instr_i;
  logic          mem_ack;
  logic          step;
  logic          mem_req, mem_we, ir_load, pc_en, pc_sel;
  logic          alu_src, reg_we, mem_to_reg, bus_err;
  logic [CW-1:0] instr_cnt;
  logic [2:0]    state_o;
  logic [W-1:0]  obs;

  // Clock.
  always #5 clk = ~clk;

  mp_multicycle_ctrl #(
    .ACK_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .instr_i    (instr_i),
    .mem_ack    (mem_ack),
`ifdef MP_CTRL_STEP_EN
    .step       (step),
`endif
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_load    (ir_load),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .alu_src    (alu_src),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .bus_err    (bus_err),
    .instr_cnt  (instr_cnt),
    .state_o    (state_o)
  );

  assign obs = {state_o, mem_req, mem_we, ir_load, pc_en, pc_sel,
                alu_src, reg_we, mem_to_reg, bus_err, instr_cnt};

  typedef struct packed {
    logic       ack;
    logic       stp;
    logic [7:0] ins;
  } stim_t;

  logic [W-1:0]  exp_q[$];
  stim_t         stim_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] m_cnt;
  logic          m_err;
  logic [7:0]    cur_ins;
  logic          cur_step;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic push_cycle(input logic [2:0] st, input logic [7:0] strb,
                            input logic ack);
    stim_t s;
    s = {ack, cur_step, cur_ins};
    exp_q.push_back({st, strb, m_err, m_cnt});
    stim_q.push_back(s);
  endtask

  // Cycle with no request: ack is randomised and must be ignored.
  task automatic push_idle(input logic [2:0] st, input logic [7:0] strb);
    push_cycle(st, strb, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_after_reset();
`ifdef MP_CTRL_STEP_EN
    push_idle(S_FETCH, 8'h00);
`endif
  endtask

  task automatic push_instr(input logic [7:0] ins, input int fw, input int mw);
    logic [7:0] mstrb;
    cur_ins = ins;
    for (int i = 0; i < fw; i++) push_cycle(S_FETCH, ST_REQ, 1'b0);
    push_cycle(S_FETCH, ST_REQ | ST_IRL | ST_PCEN, 1'b1);
    push_idle(S_DECODE, 8'h00);
    case (ins[7:6])
      2'b00: begin
        push_idle(S_EXEC, 8'h00);
        push_idle(S_WB, ST_REGWE);
      end
      2'b01, 2'b10: begin
        mstrb = ST_REQ | ST_ALUSRC | ((ins[7:6] == 2'b10) ? ST_WE : 8'h00);
        push_idle(S_ADDR, ST_ALUSRC);
        for (int i = 0; i < mw; i++) push_cycle(S_MEM, mstrb, 1'b0);
        push_cycle(S_MEM, mstrb, 1'b1);
        if (ins[7:6] == 2'b01) push_idle(S_LWB, ST_REGWE | ST_M2R);
      end
      default: begin
        push_idle(S_JUMP, ST_PCEN | ST_PCSEL);
      end
    endcase
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic push_fetch_timeout();
    for (int i = 0; i < TO; i++) push_cycle(S_FETCH, ST_REQ, 1'b0);
    m_err = 1'b1;
  endtask

  task automatic push_mem_timeout(input logic [7:0] ins);
    logic [7:0] mstrb;
    cur_ins = ins;
    mstrb = ST_REQ | ST_ALUSRC | ((ins[7:6] == 2'b10) ? ST_WE : 8'h00);
    push_cycle(S_FETCH, ST_REQ | ST_IRL | ST_PCEN, 1'b1);
    push_idle(S_DECODE, 8'h00);
    push_idle(S_ADDR, ST_ALUSRC);
    for (int i = 0; i < TO; i++) push_cycle(S_MEM, mstrb, 1'b0);
    m_err = 1'b1;
  endtask

  // Drive one queued cycle after each rising edge, compare at the falling edge.
  task automatic run_queue();
    stim_t        s;
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      s       = stim_q.pop_front();
      Reset   = 1'b0;
      mem_ack = s.ack;
      step    = s.stp;
      instr_i = s.ins;
      @(negedge clk);
      e = exp_q.pop_front();
      check_val("cyc", 32'(obs), 32'(e));
    end
  endtask

  initial begin
    Reset    = 1'b1;
    mem_ack  = 1'b0;
    instr_i  = 8'h00;
    step     = 1'b1;
    cur_step = 1'b1;
    cur_ins  = 8'h00;
    m_cnt    = '0;
    m_err    = 1'b0;

    // Reset held for 5 cycles.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("rst_vec", 32'(obs), 32'({S_FETCH, 8'h00, 1'b0, 4'h0}));

    // Directed instructions, timeouts, then a random stream.
    push_after_reset();
    push_instr(8'h1B, 0, 0);
    push_instr(8'h5A, 0, 2);
    push_instr(8'h9A, 0, 0);
    push_instr(8'hC5, 0, 0);
    push_instr(8'h1B, 1, 0);
    push_instr(8'h5A, TO - 1, TO - 1);
    push_fetch_timeout();
    push_instr(8'h1B, 0, 0);
    push_mem_timeout(8'h9A);
    push_instr(8'h5A, 0, 0);
    for (int i = 0; i < 30; i++) begin
      push_instr(8'($urandom_range(0, 255)), $urandom_range(0, TO - 1),
                 $urandom_range(0, TO - 1));
    end
    run_queue();

    // Reset asserted during MEM with an ack in the same cycle.
    cur_ins = 8'h5A;
    push_cycle(S_FETCH, ST_REQ | ST_IRL | ST_PCEN, 1'b1);
    push_idle(S_DECODE, 8'h00);
    push_idle(S_ADDR, ST_ALUSRC);
    run_queue();
    @(posedge clk);
    #1;
    Reset   = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    check_val("rst_mem_regwe", 32'(reg_we), 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check_val("rst_mem_state", 32'(state_o), 32'(S_FETCH));
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_regwe2", 32'(reg_we), 32'd0);
    check_val("rst_mem_cnt", 32'(instr_cnt), 32'd0);
    check_val("rst_mem_err", 32'(bus_err), 32'd0);
    m_cnt = '0;
    m_err = 1'b0;
    push_after_reset();
    push_instr(8'h1B, 0, 0);
    run_queue();

`ifdef MP_CTRL_STEP_EN
    // Single-step: idle without a step, then exactly one instruction.
    @(posedge clk);
    #1;
    Reset    = 1'b1;
    step     = 1'b0;
    cur_step = 1'b0;
    m_cnt    = '0;
    m_err    = 1'b0;
    repeat (20) push_idle(S_FETCH, 8'h00);
    cur_step = 1'b1;
    push_idle(S_FETCH, 8'h00);
    cur_step = 1'b0;
    push_instr(8'h1B, 0, 0);
    repeat (5) push_idle(S_FETCH, 8'h00);
    run_queue();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
